win_conv_filter: RTL and testbench
==================================

WIN_CONV_FILTER -- requirements
Module: win_conv_filter

Interface
REQ-001 The block SHALL have parameter PX_WIDTH, default 12, meaning unsigned pixel width.
REQ-002 The block SHALL have parameter PX_PER_CLK, default 4, meaning pixels (lanes) per clock.
REQ-003 The block SHALL have parameter WIN_SIZE, default 5, meaning odd window edge length.
REQ-004 The block SHALL have parameter COEF_WIDTH, default 8, meaning signed two's-complement coefficient width.
REQ-005 The block SHALL have parameter COEF_FRAC, default 4 (at least 1), meaning the number of coefficient fractional bits.
REQ-006 clk_i  in  1  clock; rst_i  in  1  reset, asynchronous, active-high.
REQ-007 win_data_i  in  [PX_PER_CLK][WIN_SIZE][WIN_SIZE][PX_WIDTH]  per-lane windows, indexed [lane][col][row].
REQ-008 win_data_val_i  in  PX_PER_CLK  per-lane window valid.
REQ-009 line_start_i, line_end_i, frame_start_i, frame_end_i  in  1 each  stream markers aligned with win_data_i.
REQ-010 coef_i  in  [WIN_SIZE][WIN_SIZE][COEF_WIDTH]  kernel, indexed [col][row].
REQ-011 coef_load_i  in  1  single-cycle strobe that captures coef_i into the shadow register.
REQ-012 px_data_o  out  [PX_PER_CLK][PX_WIDTH]  filtered pixels.
REQ-013 px_data_val_o  out  PX_PER_CLK  per-lane valid.
REQ-014 line_start_o, line_end_o, frame_start_o, frame_end_o  out  1 each  delayed markers.
REQ-015 sat_o  out  1  high when any valid lane was clipped in the same output beat.
REQ-016 coef_pending_o  out  1  high while loaded coefficients await application.

Function
REQ-017 Each lane SHALL compute acc = sum over all WIN_SIZE^2 taps of (pixel zero-extended by 1 bit) x coef, full precision, with ACC_W = PX_WIDTH+1+COEF_WIDTH+clog2(WIN_SIZE^2).
REQ-018 The result SHALL be rounded half-up: add 2^(COEF_FRAC-1), then arithmetic right shift by COEF_FRAC.
REQ-019 The rounded result SHALL be clamped to [0, 2^PX_WIDTH-1]; sat_o asserts if any valid lane clamped.
REQ-020 The datapath SHALL be fully pipelined, accepting one beat per cycle with no backpressure.
REQ-021 Pipeline stages SHALL be: 1 multiply register, then T = clog2(WIN_SIZE^2) registered pairwise adder levels (odd operands zero-padded), then 1 round/clamp register.
REQ-022 Latency SHALL be L = T + 2 cycles (7 at defaults), identical for data, valid, markers and sat_o.
REQ-023 Lanes with win_data_val_i low SHALL produce px_data_o = 0 and px_data_val_o = 0 after L cycles.
REQ-024 Markers SHALL be delayed exactly L cycles through a shift register, independent of valid.
REQ-025 coef_load_i SHALL write the shadow register and set coef_pending_o on the next cycle.
REQ-026 The active kernel SHALL update from the shadow only on a cycle with frame_start_i high, so that kernel changes never occur mid-frame.
REQ-027 If coef_load_i and frame_start_i coincide, coef_i SHALL be bypassed directly into the active kernel and coef_pending_o SHALL stay low.
REQ-028 The active kernel SHALL be sampled at the multiply stage, so the first beat of a frame already uses the new kernel.
REQ-029 coef_pending_o SHALL clear on the cycle after application; a reload while pending SHALL overwrite the shadow (last load wins).

Reset
REQ-030 On rst_i, all pipeline registers, px_data_o, px_data_val_o, markers, sat_o and coef_pending_o SHALL be 0.
REQ-031 On rst_i, the active and shadow kernels SHALL be the identity: centre tap = 2^COEF_FRAC, all other taps = 0.
REQ-032 rst_i asserted mid-frame SHALL discard all in-flight beats; no partial output SHALL appear after release.

Structure
REQ-033 Package win_conv_pkg SHALL hold the functions for T, L and ACC_W and the identity-kernel constant function.
REQ-034 A sub-module pipe_adder_tree (parameters N, W; registered levels; latency clog2(N)) SHALL be instantiated once per lane.

Verification
REQ-035 Reset defaults (identity kernel), window centre 0xABC on all lanes, all valid -> px_data_o = 0xABC on every lane after exactly 7 cycles, sat_o = 0.
REQ-036 Box kernel of all taps 1 with COEF_FRAC=4 on windows of all 0x010 -> output (25x16+8)>>4 = 25 = 0x019.
REQ-037 Centre tap -1, input 0x100 -> output 0 with sat_o = 1; centre tap 127 with input 0xFFF -> output 0xFFF with sat_o = 1.
REQ-038 Load a new kernel mid-frame -> old kernel holds until frame end, coef_pending_o = 1; next frame_start_i applies it and coef_pending_o drops one cycle later; a load on the same cycle as frame_start_i applies immediately with no pending pulse.
REQ-039 Random lane valid masks plus markers -> markers and masks reappear 7 cycles later; invalid lanes output 0.
REQ-040 Assert rst_i for 1 cycle mid-frame -> all outputs 0 from the reset edge, kernel returns to identity, no stale valids afterward.

Source files
------------

// File: rtl/win_conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | win_conv_pkg: sizing helpers, marker bundle and identity kernel taps        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package win_conv_pkg;

  typedef struct packed {
    logic frame_start;
    logic line_start;
    logic line_end;
    logic frame_end;
  } marker_t;

  function automatic int calc_tree_levels(input int win_size);
    return $clog2(win_size * win_size);
  endfunction

  function automatic int calc_latency(input int win_size);
    return calc_tree_levels(win_size) + 2;
  endfunction

  function automatic int calc_acc_w(input int px_width, input int coef_width, input int win_size);
    return px_width + 1 + coef_width + calc_tree_levels(win_size);
  endfunction

  // Unity gain: only the centre tap is non-zero, at 1.0 in the coefficient format.
  function automatic int identity_tap(input int col, input int row, input int win_size,
                                      input int coef_frac);
    return ((col == win_size / 2) && (row == win_size / 2)) ? (1 << coef_frac) : 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_adder_tree.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_adder_tree: registered pairwise signed adder tree, latency clog2(N)    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pipe_adder_tree #(
  parameter int N = 25,
  parameter int W = 21
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N-1:0][W-1:0]         operands_i,
  output logic [W+$clog2(N)-1:0]      sum_o
);

  localparam int LEVELS = $clog2(N);
  localparam int OW     = W + LEVELS;

  function automatic int nodes_at(input int lvl);
    return (N + (1 << lvl) - 1) >> lvl;
  endfunction

  // Offset of a level inside the flat register array (level 1 starts at 0).
  function automatic int reg_offset(input int lvl);
    int off;
    off = 0;
    for (int k = 1; k < lvl; k++) off += nodes_at(k);
    return off;
  endfunction

  if (LEVELS == 0) begin : g_bypass
    assign sum_o = operands_i[0];
  end else begin : g_tree
    localparam int REG_NODES = reg_offset(LEVELS + 1);

    logic [OW-1:0] w_leaf [N];
    logic [OW-1:0] w_next [REG_NODES];
    logic [OW-1:0] r_node [REG_NODES];

    for (genvar i = 0; i < N; i++) begin : g_leaf
      assign w_leaf[i] = OW'($signed(operands_i[i]));
    end

    for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_lvl
      localparam int NP   = nodes_at(lv - 1);
      localparam int NC   = nodes_at(lv);
      localparam int OFFP = reg_offset(lv - 1);
      localparam int OFFC = reg_offset(lv);
      for (genvar i = 0; i < NC; i++) begin : g_node
        logic [OW-1:0] w_a;
        logic [OW-1:0] w_b;
        if (lv == 1) begin : g_src_leaf
          assign w_a = w_leaf[2*i];
          if (2*i + 1 < NP) begin : g_pair
            assign w_b = w_leaf[2*i+1];
          end else begin : g_pad
            assign w_b = '0;
          end
        end else begin : g_src_reg
          assign w_a = r_node[OFFP + 2*i];
          if (2*i + 1 < NP) begin : g_pair
            assign w_b = r_node[OFFP + 2*i + 1];
          end else begin : g_pad
            assign w_b = '0;
          end
        end
        assign w_next[OFFC + i] = w_a + w_b;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        r_node <= '{default: '0};
      end else begin
        r_node <= w_next;
      end
    end

    assign sum_o = r_node[REG_NODES-1];
  end

endmodule
`default_nettype wire

// File: rtl/win_conv_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | win_conv_filter: multi-lane windowed convolution, round/clamp, frame-safe   |
// | kernel update. Revision: 1.0                                                |
// +----------------------------------------------------------------------------+
module win_conv_filter
  import win_conv_pkg::*;
#(
  parameter int PX_WIDTH   = 12,
  parameter int PX_PER_CLK = 4,
  parameter int WIN_SIZE   = 5,
  parameter int COEF_WIDTH = 8,
  parameter int COEF_FRAC  = 4
) (
  input  logic                                                      clk_i,
  input  logic                                                      rst_i,
  input  logic [PX_PER_CLK-1:0][WIN_SIZE-1:0][WIN_SIZE-1:0][PX_WIDTH-1:0] win_data_i,
  input  logic [PX_PER_CLK-1:0]                                     win_data_val_i,
  input  logic                                                      line_start_i,
  input  logic                                                      line_end_i,
  input  logic                                                      frame_start_i,
  input  logic                                                      frame_end_i,
  input  logic [WIN_SIZE-1:0][WIN_SIZE-1:0][COEF_WIDTH-1:0]         coef_i,
  input  logic                                                      coef_load_i,
  output logic [PX_PER_CLK-1:0][PX_WIDTH-1:0]                       px_data_o,
  output logic [PX_PER_CLK-1:0]                                     px_data_val_o,
  output logic                                                      line_start_o,
  output logic                                                      line_end_o,
  output logic                                                      frame_start_o,
  output logic                                                      frame_end_o,
  output logic                                                      sat_o,
  output logic                                                      coef_pending_o
);

  localparam int TAPS   = WIN_SIZE * WIN_SIZE;
  localparam int L      = calc_latency(WIN_SIZE);
  localparam int PROD_W = PX_WIDTH + 1 + COEF_WIDTH;
  localparam int ACC_W  = calc_acc_w(PX_WIDTH, COEF_WIDTH, WIN_SIZE);

  typedef logic [WIN_SIZE-1:0][WIN_SIZE-1:0][COEF_WIDTH-1:0] kernel_t;

  function automatic kernel_t identity_kernel();
    kernel_t k;
    for (int c = 0; c < WIN_SIZE; c++)
      for (int r = 0; r < WIN_SIZE; r++)
        k[c][r] = COEF_WIDTH'(identity_tap(c, r, WIN_SIZE, COEF_FRAC));
    return k;
  endfunction

  localparam kernel_t                  c_identity = identity_kernel();
  localparam logic signed [ACC_W-1:0]  c_half     = ACC_W'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0]  c_px_max   = {{(ACC_W-PX_WIDTH){1'b0}}, {PX_WIDTH{1'b1}}};

  kernel_t r_active;
  kernel_t r_shadow;
  kernel_t w_kernel;
  logic    r_coef_pending;

  // A frame start applies the shadow, or the incoming kernel when loaded on the same beat.
  assign w_kernel = frame_start_i ? (coef_load_i ? coef_i : r_shadow) : r_active;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_active       <= c_identity;
      r_shadow       <= c_identity;
      r_coef_pending <= 1'b0;
    end else begin
      if (coef_load_i) r_shadow <= coef_i;
      if (frame_start_i) begin
        r_active       <= w_kernel;
        r_coef_pending <= 1'b0;
      end else if (coef_load_i) begin
        r_coef_pending <= 1'b1;
      end
    end
  end

  assign coef_pending_o = r_coef_pending;

  // Valid travels alongside the datapath up to the round/clamp stage.
  logic [PX_PER_CLK-1:0] r_val_sr  [L-1];
  marker_t               r_mark_sr [L];
  marker_t               w_mark_in;

  assign w_mark_in = '{frame_start: frame_start_i, line_start: line_start_i,
                       line_end: line_end_i, frame_end: frame_end_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < L - 1; i++) r_val_sr[i] <= '0;
      for (int i = 0; i < L; i++) r_mark_sr[i] <= '0;
    end else begin
      r_val_sr[0] <= win_data_val_i;
      for (int i = 1; i < L - 1; i++) r_val_sr[i] <= r_val_sr[i-1];
      r_mark_sr[0] <= w_mark_in;
      for (int i = 1; i < L; i++) r_mark_sr[i] <= r_mark_sr[i-1];
    end
  end

  assign frame_start_o = r_mark_sr[L-1].frame_start;
  assign line_start_o  = r_mark_sr[L-1].line_start;
  assign line_end_o    = r_mark_sr[L-1].line_end;
  assign frame_end_o   = r_mark_sr[L-1].frame_end;

  logic [PX_PER_CLK-1:0][PX_WIDTH-1:0] w_clip;
  logic [PX_PER_CLK-1:0]               w_sat;

  for (genvar ln = 0; ln < PX_PER_CLK; ln++) begin : g_lane
    logic [TAPS-1:0][PROD_W-1:0] w_prod;
    logic [TAPS-1:0][PROD_W-1:0] r_prod;
    logic signed [ACC_W-1:0]     w_acc;
    logic signed [ACC_W-1:0]     w_sum;
    logic signed [ACC_W-1:0]     w_rnd;

    for (genvar c = 0; c < WIN_SIZE; c++) begin : g_col
      for (genvar r = 0; r < WIN_SIZE; r++) begin : g_row
        logic signed [PROD_W-1:0] w_px;
        logic signed [PROD_W-1:0] w_cf;
        assign w_px = PROD_W'({1'b0, win_data_i[ln][c][r]});
        assign w_cf = PROD_W'($signed(w_kernel[c][r]));
        assign w_prod[c*WIN_SIZE + r] = w_px * w_cf;
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_prod <= '0;
      else       r_prod <= w_prod;
    end

    pipe_adder_tree #(
      .N (TAPS),
      .W (PROD_W)
    ) u_tree (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .operands_i (r_prod),
      .sum_o      (w_acc)
    );

    assign w_sum       = w_acc + c_half;
    assign w_rnd       = w_sum >>> COEF_FRAC;
    assign w_sat[ln]   = (w_rnd < 0) || (w_rnd > c_px_max);
    assign w_clip[ln]  = (w_rnd < 0)        ? '0 :
                         (w_rnd > c_px_max) ? {PX_WIDTH{1'b1}} : w_rnd[PX_WIDTH-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      px_data_o     <= '0;
      px_data_val_o <= '0;
      sat_o         <= 1'b0;
    end else begin
      for (int ln = 0; ln < PX_PER_CLK; ln++)
        px_data_o[ln] <= r_val_sr[L-2][ln] ? w_clip[ln] : '0;
      px_data_val_o <= r_val_sr[L-2];
      sat_o         <= |(w_sat & r_val_sr[L-2]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_win_conv_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_win_conv_filter: directed scoreboard bench for win_conv_filter           |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_win_conv_filter;

  localparam int LANES = 4;
  localparam int WS    = 5;
  localparam int PXW   = 12;
  localparam int CW    = 8;
  localparam int FRAC  = 4;
  localparam int LAT   = 7;

  localparam logic [3:0] M_NONE = 4'b0000;
  localparam logic [3:0] M_FS   = 4'b1000;
  localparam logic [3:0] M_LS   = 4'b0100;
  localparam logic [3:0] M_LE   = 4'b0010;
  localparam logic [3:0] M_FE   = 4'b0001;

  typedef logic [LANES-1:0][WS-1:0][WS-1:0][PXW-1:0] win_t;
  typedef logic [WS-1:0][WS-1:0][CW-1:0]             ker_t;
  typedef struct {
    logic [LANES-1:0][PXW-1:0] px;
    logic [LANES-1:0]          val;
    logic [3:0]                mark;
    logic                      sat;
    int                        due;
  } exp_t;

  logic                      clk_i = 1'b0;
  logic                      rst_i;
  win_t                      win_data_i;
  logic [LANES-1:0]          win_data_val_i;
  logic                      line_start_i, line_end_i, frame_start_i, frame_end_i;
  ker_t                      coef_i;
  logic                      coef_load_i;
  logic [LANES-1:0][PXW-1:0] px_data_o;
  logic [LANES-1:0]          px_data_val_o;
  logic                      line_start_o, line_end_o, frame_start_o, frame_end_o;
  logic                      sat_o;
  logic                      coef_pending_o;

  win_conv_filter #(
    .PX_WIDTH   (PXW),
    .PX_PER_CLK (LANES),
    .WIN_SIZE   (WS),
    .COEF_WIDTH (CW),
    .COEF_FRAC  (FRAC)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .win_data_i     (win_data_i),
    .win_data_val_i (win_data_val_i),
    .line_start_i   (line_start_i),
    .line_end_i     (line_end_i),
    .frame_start_i  (frame_start_i),
    .frame_end_i    (frame_end_i),
    .coef_i         (coef_i),
    .coef_load_i    (coef_load_i),
    .px_data_o      (px_data_o),
    .px_data_val_o  (px_data_val_o),
    .line_start_o   (line_start_o),
    .line_end_o     (line_end_o),
    .frame_start_o  (frame_start_o),
    .frame_end_o    (frame_end_o),
    .sat_o          (sat_o),
    .coef_pending_o (coef_pending_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;
  exp_t sb[$];
  win_t win;
  ker_t m_active, m_shadow;
  logic m_pending;
  ker_t k_id, k_box, k_neg, k_pos, k_a, k_b;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ker_t centre_ker(input logic [CW-1:0] v);
    ker_t k;
    k = '0;
    k[WS/2][WS/2] = v;
    return k;
  endfunction

  function automatic ker_t rand_ker();
    ker_t k;
    for (int c = 0; c < WS; c++)
      for (int r = 0; r < WS; r++)
        k[c][r] = CW'(int'($urandom_range(0, 24)) - 12);
    return k;
  endfunction

  task automatic rand_win();
    for (int ln = 0; ln < LANES; ln++)
      for (int c = 0; c < WS; c++)
        for (int r = 0; r < WS; r++)
          win[ln][c][r] = PXW'($urandom_range(0, 4095));
  endtask

  task automatic fill_win(input logic [PXW-1:0] v);
    for (int ln = 0; ln < LANES; ln++)
      for (int c = 0; c < WS; c++)
        for (int r = 0; r < WS; r++)
          win[ln][c][r] = v;
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk_i);
    cycle++;
    #1;
    check("coef_pending", 64'(coef_pending_o), 64'(m_pending));
    while (sb.size() > 0 && sb[0].due == cycle) begin
      e = sb.pop_front();
      check("px_data", 64'(px_data_o), 64'(e.px));
      check("px_val", 64'(px_data_val_o), 64'(e.val));
      check("markers", 64'({frame_start_o, line_start_o, line_end_o, frame_end_o}), 64'(e.mark));
      check("sat", 64'(sat_o), 64'(e.sat));
    end
  endtask

  // Drive one beat from the current window set, predict its result and advance a cycle.
  task automatic beat(input logic [LANES-1:0] val, input logic [3:0] mark,
                      input logic load, input ker_t k);
    ker_t   used;
    exp_t   e;
    longint acc, r;
    win_data_i     = win;
    win_data_val_i = val;
    {frame_start_i, line_start_i, line_end_i, frame_end_i} = mark;
    coef_i         = k;
    coef_load_i    = load;
    if (mark[3]) begin
      used      = load ? k : m_shadow;
      m_active  = used;
      m_shadow  = used;
      m_pending = 1'b0;
    end else begin
      used = m_active;
      if (load) begin
        m_shadow  = k;
        m_pending = 1'b1;
      end
    end
    e.px   = '0;
    e.val  = val;
    e.mark = mark;
    e.sat  = 1'b0;
    for (int ln = 0; ln < LANES; ln++) begin
      if (val[ln]) begin
        acc = 0;
        for (int c = 0; c < WS; c++)
          for (int rw = 0; rw < WS; rw++)
            acc += longint'(win[ln][c][rw]) * longint'($signed(used[c][rw]));
        r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
        if (r < 0) begin
          e.px[ln] = '0;
          e.sat    = 1'b1;
        end else if (r > 4095) begin
          e.px[ln] = 12'hFFF;
          e.sat    = 1'b1;
        end else begin
          e.px[ln] = PXW'(r);
        end
      end
    end
    e.due = cycle + LAT;
    sb.push_back(e);
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_px"}, 64'(px_data_o), 64'h0);
    check({tag, "_val"}, 64'(px_data_val_o), 64'h0);
    check({tag, "_markers"}, 64'({frame_start_o, line_start_o, line_end_o, frame_end_o}), 64'h0);
    check({tag, "_sat"}, 64'(sat_o), 64'h0);
    check({tag, "_pending"}, 64'(coef_pending_o), 64'h0);
  endtask

  initial begin
    k_id  = centre_ker(8'd16);
    k_box = '0;
    for (int c = 0; c < WS; c++)
      for (int r = 0; r < WS; r++)
        k_box[c][r] = 8'd1;
    k_neg = centre_ker(8'hFF);
    k_pos = centre_ker(8'd127);
    k_a   = rand_ker();
    k_b   = rand_ker();

    m_active  = k_id;
    m_shadow  = k_id;
    m_pending = 1'b0;
    rst_i          = 1'b1;
    win            = '0;
    win_data_i     = '0;
    win_data_val_i = '0;
    {frame_start_i, line_start_i, line_end_i, frame_end_i} = 4'b0000;
    coef_i         = '0;
    coef_load_i    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_outputs_zero("reset");
    rst_i = 1'b0;

    // Identity kernel from reset: centre pixel passes straight through.
    rand_win();
    for (int ln = 0; ln < LANES; ln++) win[ln][WS/2][WS/2] = 12'hABC;
    beat(4'hF, M_FS | M_LS, 1'b0, k_id);
    for (int i = 0; i < 3; i++) begin
      rand_win();
      beat(4'hF, (i == 2) ? M_LE : M_NONE, 1'b0, k_id);
    end

    // Box kernel bypassed on frame start.
    fill_win(12'h010);
    beat(4'hF, M_FS, 1'b1, k_box);
    beat(4'hF, M_NONE, 1'b0, k_id);

    // Saturation at both ends, and an invalid lane that would clip.
    fill_win(12'h000);
    for (int ln = 0; ln < LANES; ln++) win[ln][WS/2][WS/2] = 12'h100;
    beat(4'hF, M_FS, 1'b1, k_neg);
    for (int ln = 0; ln < LANES; ln++) win[ln][WS/2][WS/2] = 12'hFFF;
    beat(4'hF, M_FS, 1'b1, k_pos);
    win[0][WS/2][WS/2] = 12'h010;
    beat(4'b0001, M_NONE, 1'b0, k_id);

    // Mid-frame loads stay pending until the next frame start; last load wins.
    rand_win();
    beat(4'hF, M_FS, 1'b1, k_id);
    beat(4'hF, M_NONE, 1'b1, k_a);
    rand_win();
    beat(4'hF, M_NONE, 1'b0, k_id);
    beat(4'hF, M_NONE, 1'b1, k_b);
    rand_win();
    beat(4'hF, M_FE, 1'b0, k_id);
    beat(4'h0, M_NONE, 1'b0, k_id);
    rand_win();
    beat(4'hF, M_FS | M_LS, 1'b0, k_id);
    rand_win();
    beat(4'hF, M_NONE, 1'b0, k_id);

    // Random lane masks and markers.
    for (int i = 0; i < 20; i++) begin
      rand_win();
      beat(LANES'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, k_id);
    end

    // Reset in the middle of a frame with a non-identity kernel and a pending load.
    rand_win();
    beat(4'hF, M_FS, 1'b1, k_a);
    beat(4'hF, M_NONE, 1'b1, k_b);
    rand_win();
    beat(4'hB, M_LS, 1'b0, k_id);
    rst_i = 1'b1;
    #1;
    foreach (sb[i]) begin
      sb[i].px   = '0;
      sb[i].val  = '0;
      sb[i].mark = '0;
      sb[i].sat  = 1'b0;
    end
    m_active  = k_id;
    m_shadow  = k_id;
    m_pending = 1'b0;
    check_outputs_zero("midreset");
    win = '0;
    beat(4'h0, M_NONE, 1'b0, k_id);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_win();
      beat(4'hF, M_NONE, 1'b0, k_id);
    end

    for (int i = 0; i < LAT + 2; i++) begin
      win = '0;
      beat(4'h0, M_NONE, 1'b0, k_id);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
